// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: parity modes and FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every divisor+1 clocks, realigned to 0 on restart.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // Equality compare only, so the counter wraps at divisor and never overflows.
  assign tick = (cnt == divisor);

  always_ff @(posedge clk) begin
    if (rst || restart) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + DIV_WIDTH'(1);
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame latched divisor, parity mode and stop-bit count.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);

  state_e               state, state_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic                 stop_cnt, stop_n;
  logic [DATA_BITS-1:0] sh_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 par_q, par_en_q, stop2_q;
  logic                 accept, tick;

  assign accept   = tx_valid && (state == S_IDLE);
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .divisor (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    stop_n  = stop_cnt;
    case (state)
      S_IDLE:  if (accept) begin state_n = S_START; bit_n = '0; stop_n = 1'b0; end
      S_START: if (tick) begin state_n = S_DATA; bit_n = '0; end
      S_DATA: if (tick) begin
        if (bit_cnt == BW'(DATA_BITS - 1)) begin
          state_n = par_en_q ? S_PARITY : S_STOP;
          stop_n  = 1'b0;
        end else begin
          bit_n = bit_cnt + BW'(1);
        end
      end
      S_PARITY: if (tick) begin state_n = S_STOP; stop_n = 1'b0; end
      S_STOP: if (tick) begin
        if (stop2_q && !stop_cnt) stop_n = 1'b1;
        else                      state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = sh_q[0];
      S_PARITY: tx = par_q;
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      sh_q     <= '0;
      div_q    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      if (accept) begin
        sh_q     <= tx_data;
        div_q    <= divisor;
        par_en_q <= parity_en(parity_mode);
        // Parity is fixed at acceptance so later tx_data changes cannot leak in.
        par_q    <= (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
        stop2_q  <= stop2;
      end else if (state == S_DATA && tick) begin
        sh_q <= {1'b0, sh_q[DATA_BITS-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit and 7-bit instances, hand-computed tx sequences.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] divisor;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [6:0]  tx_data7;
  logic        tx_valid7;
  logic        tx8, rdy8, busy8;
  logic        tx7, rdy7, busy7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .DIV_WIDTH(24)) dut8 (
    .clk(clk), .rst(rst), .divisor(divisor), .parity_mode(parity_mode), .stop2(stop2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy8), .tx(tx8), .busy(busy8)
  );

  uart_tx_cfg #(.DATA_BITS(7), .DIV_WIDTH(24)) dut7 (
    .clk(clk), .rst(rst), .divisor(divisor), .parity_mode(parity_mode), .stop2(stop2),
    .tx_data(tx_data7), .tx_valid(tx_valid7), .tx_ready(rdy7), .tx(tx7), .busy(busy7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Disturb every input the transmitter should have latched, and request again while busy.
  task automatic perturb(input bit which);
    divisor     = divisor + 24'd5;
    parity_mode = ~parity_mode;
    stop2       = ~stop2;
    tx_data     = ~tx_data;
    tx_data7    = ~tx_data7;
    if (which) tx_valid7 = 1'b1;
    else       tx_valid  = 1'b1;
  endtask

  // Called at a negedge with inputs set; returns at the negedge of the first START cycle.
  task automatic start_frame(input bit which, input bit keep);
    chk("ready_before_accept", which ? rdy7 : rdy8, 1'b1);
    if (which) tx_valid7 = 1'b1;
    else       tx_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) begin tx_valid = 1'b0; tx_valid7 = 1'b0; end
  endtask

  // seq[i] is the i-th bit on the line; each bit must last div+1 cycles.
  task automatic check_frame(input string name, input logic [15:0] seq, input int len,
                             input int div, input bit which, input int mid, input bit keep);
    int cyc = 0;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c <= div; c++) begin
        if (cyc == mid) perturb(which);
        chk($sformatf("%s tx bit%0d cyc%0d", name, i, c), which ? tx7 : tx8, seq[i]);
        chk($sformatf("%s busy bit%0d cyc%0d", name, i, c), which ? busy7 : busy8, 1'b1);
        cyc++;
        @(negedge clk);
      end
    end
    if (!keep) begin tx_valid = 1'b0; tx_valid7 = 1'b0; end
    chk({name, " idle busy"},  which ? busy7 : busy8, 1'b0);
    chk({name, " idle ready"}, which ? rdy7 : rdy8, 1'b1);
    chk({name, " idle tx"},    which ? tx7 : tx8, 1'b1);
  endtask

  initial begin
    rst = 1'b1; divisor = 24'd0; parity_mode = 2'b00; stop2 = 1'b0;
    tx_data = 8'hFF; tx_valid = 1'b1; tx_data7 = 7'h00; tx_valid7 = 1'b1;

    // Reset held with tx_valid high: no acceptance.
    repeat (3) @(negedge clk);
    chk("rst tx",    tx8, 1'b1);
    chk("rst ready", rdy8, 1'b1);
    chk("rst busy",  busy8, 1'b0);
    chk("rst busy7", busy7, 1'b0);
    tx_valid = 1'b0; tx_valid7 = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst busy", busy8, 1'b0);

    // 0x55, divisor 3, no parity, one stop: 10 bits x 4 cycles.
    divisor = 24'd3; parity_mode = 2'b00; stop2 = 1'b0; tx_data = 8'h55;
    start_frame(0, 0);
    check_frame("f55", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 3, 0, -1, 0);

    // 0xA5 even parity -> parity bit 0; inputs disturbed mid-frame.
    divisor = 24'd1; parity_mode = 2'b01; tx_data = 8'hA5;
    start_frame(0, 0);
    check_frame("fA5e", {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1, 0, 5, 0);

    // 0xA5 odd parity -> parity bit 1.
    divisor = 24'd1; parity_mode = 2'b10; stop2 = 1'b0; tx_data = 8'hA5;
    start_frame(0, 0);
    check_frame("fA5o", {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1, 0, 7, 0);

    // Back-to-back with tx_valid held, divisor 0; 0x80 presented while busy must wait.
    divisor = 24'd0; parity_mode = 2'b00; stop2 = 1'b0; tx_data = 8'h01;
    start_frame(0, 1);
    tx_data = 8'h80;
    check_frame("b2b1", {6'b0, 1'b1, 8'h01, 1'b0}, 10, 0, 0, -1, 1);
    @(negedge clk);
    check_frame("b2b2", {6'b0, 1'b1, 8'h80, 1'b0}, 10, 0, 0, -1, 0);

    // Reset during data bit 3 (cycle 17 of a divisor-3 frame).
    divisor = 24'd3; parity_mode = 2'b00; stop2 = 1'b0; tx_data = 8'h55;
    start_frame(0, 0);
    repeat (17) @(negedge clk);
    chk("mid data bit3", tx8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort tx",    tx8, 1'b1);
    chk("abort ready", rdy8, 1'b1);
    chk("abort busy",  busy8, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort hold tx%0d", k), tx8, 1'b1);
      chk($sformatf("abort hold busy%0d", k), busy8, 1'b0);
    end
    divisor = 24'd2; parity_mode = 2'b10; tx_data = 8'hC3;
    start_frame(0, 0);
    check_frame("fC3o", {5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11, 2, 0, -1, 0);

    // 7-bit instance, two stop bits, divisor disturbed mid-frame.
    divisor = 24'd2; parity_mode = 2'b00; stop2 = 1'b1; tx_data7 = 7'h5A;
    start_frame(1, 0);
    check_frame("f7", {6'b0, 1'b1, 1'b1, 7'h5A, 1'b0}, 10, 2, 1, 4, 0);
    chk("f7 dut8 idle", busy8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter DIV_WIDTH, default 24, width of the baud divisor.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port divisor  input  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-006 SHALL have port parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-007 SHALL have port stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-008 SHALL have port tx_data  input  DATA_BITS  byte to send.
REQ-009 SHALL have port tx_valid  input  1  tx_data holds a frame request.
REQ-010 SHALL have port tx_ready  output  1  block accepts a request this cycle.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress (any state other than IDLE).

Function
REQ-013 SHALL accept a frame on a cycle where tx_valid && tx_ready, and latch tx_data, divisor, parity_mode and stop2 on that edge.
REQ-014 SHALL ignore changes to the config inputs and tx_data after acceptance, until the next acceptance.
REQ-015 SHALL implement the FSM IDLE -> START -> DATA -> PARITY (only if parity enabled) -> STOP -> IDLE.
REQ-016 SHALL drive tx_ready = 1 only in IDLE; tx_valid outside IDLE has no effect.
REQ-017 SHALL drive tx low (start bit) from the cycle after acceptance.
REQ-018 SHALL hold each bit for exactly latched_divisor+1 clk cycles; divisor 0 gives one-cycle bits.
REQ-019 SHALL send the data LSB first: bit 0 first, bit DATA_BITS-1 last.
REQ-020 SHALL set the parity bit so the total count of ones in data plus parity is even (mode 01) or odd (mode 10).
REQ-021 SHALL drive tx high for one (stop2=0) or two (stop2=1) stop bit periods, then enter IDLE.
REQ-022 SHALL take frame length (1+DATA_BITS+P+S)*(divisor+1) cycles from start edge to IDLE entry, where P is 0 or 1 and S is 1 or 2.
REQ-023 SHALL hold tx high in IDLE.
REQ-024 SHALL allow back-to-back frames: with tx_valid held, acceptance occurs on the first IDLE cycle, so the gap between frames is exactly one clk cycle of extra stop time.
REQ-025 SHALL restart the baud counter at 0 on acceptance, so the start bit is aligned to that cycle and not to a free-running tick.
REQ-026 SHALL keep all counters within their widths; the divisor compare SHALL be an equality at DIV_WIDTH bits, with no overflow path.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, go to IDLE with tx=1, tx_ready=1, busy=0, and clear the bit and baud counters.
REQ-028 SHALL make rst dominate tx_valid in the same cycle; no acceptance occurs.
REQ-029 SHALL abandon a frame on reset mid-frame: tx returns high on the next edge and the frame is not resumed.

Structure
REQ-030 SHALL place the parity-mode encodings and FSM state encodings in shared package uart_pkg.
REQ-031 SHALL contain one sub-module, uart_baud_tick (clk, rst, restart, divisor -> tick), a one-cycle tick every divisor+1 cycles.
REQ-032 SHALL use no derived or gated clocks; all state changes are qualified by tick.

Verification
REQ-033 SHALL cover: DATA_BITS=8, divisor=3, mode 00, stop2=0, tx_data=0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy for 40 cycles.
REQ-034 SHALL cover: tx_data=0xA5, mode 01 -> parity bit 0; mode 10 -> parity bit 1; frame 11 bits.
REQ-035 SHALL cover: tx_valid held high for two frames, 0x01 then 0x80, divisor=0 -> second start bit exactly 1 cycle after first frame's IDLE entry.
REQ-036 SHALL cover: rst pulsed during data bit 3 -> tx=1, tx_ready=1 next cycle; next frame is bit-exact.
REQ-037 SHALL cover: DATA_BITS=7, stop2=1, divisor changed mid-frame -> frame uses the latched divisor, with 2 stop periods.
REQ-038 SHALL cover: tx_valid asserted while busy -> no acceptance and tx_data not re-latched.
